// File: rtl/data_ram_arbiter_if.sv
// Signal bundle between the data RAM arbiter, its requesters and the RAM port.
// slave is the arbiter's view; master is the requester/RAM side.
interface data_ram_arbiter_if #(
    parameter int unsigned AW   = 16,
    parameter int unsigned DW   = 8,
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_din;
    logic [DW-1:0]      ram_dout;
    logic               lock_timeout;

    modport slave (
        input  req, we, addr, wdata, lock, ram_dout,
        output gnt, rvalid, rdata, ram_we, ram_addr, ram_din, lock_timeout
    );

    modport master (
        output req, we, addr, wdata, lock, ram_dout,
        input  gnt, rvalid, rdata, ram_we, ram_addr, ram_din, lock_timeout
    );
endinterface

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between CPU, UART loader
// and UART dumper, with optional bus lock and tagged read-data return.
module data_ram_arbiter #(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 8,
    parameter int unsigned NREQ     = 3,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned LOCK_MAX = 256
) (
    input  logic              clk,
    input  logic              reset,
    data_ram_arbiter_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

    state_t                         state_q, state_d;
    logic [PW-1:0]                  ptr_q, ptr_d;
    logic [PW-1:0]                  owner_q, owner_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [AW-1:0]                  addr_q, addr_d;
    logic [DW-1:0]                  din_q, din_d;
    logic [RD_LAT-1:0][NREQ-1:0]    tag_q, tag_d;

    logic                           found;
    logic [PW-1:0]                  winner;
    logic [PW-1:0]                  sel;
    logic                           grant;
    logic                           timeout;
    logic                           we_out;
    logic [NREQ-1:0]                gnt;
    logic [NREQ-1:0]                owner_mask;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (32'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // First requester at or above the pointer; otherwise the first one below it.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && bus.req[i] && (i >= 32'(ptr_q))) begin
                found  = 1'b1;
                winner = PW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && bus.req[i]) begin
                found  = 1'b1;
                winner = PW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        sel     = winner;
        grant   = 1'b0;
        timeout = 1'b0;
        gnt     = '0;
        we_out  = 1'b0;

        case (state_q)
            ST_ARB: begin
                sel   = winner;
                grant = found;
                if (found && bus.lock[winner]) begin
                    owner_d = winner;
                    cnt_d   = CW'(1);
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                sel = owner_q;
                // The expiry cycle grants nobody, so a lock spans at most LOCK_MAX grant cycles.
                if (cnt_q == CW'(LOCK_MAX)) begin
                    timeout = 1'b1;
                    ptr_d   = next_idx(owner_q);
                    state_d = ST_ARB;
                end else begin
                    grant = bus.req[owner_q];
                    cnt_d = cnt_q + 1'b1;
                    if (!bus.lock[owner_q]) begin
                        state_d = ST_ARB;
                    end
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        if (!reset) begin
            grant = 1'b0;
        end

        if (grant) begin
            gnt[sel] = 1'b1;
            we_out   = bus.we[sel];
            ptr_d    = next_idx(sel);
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (sel == PW'(i)) begin
                    addr_d = bus.addr[i*AW +: AW];
                    din_d  = bus.wdata[i*DW +: DW];
                end
            end
        end
    end

    // Writes enter a zero tag so the pipe stays aligned with the RAM latency.
    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = gnt & ~bus.we;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.gnt          = gnt;
    assign bus.ram_we       = we_out;
    assign bus.ram_addr     = addr_d;
    assign bus.ram_din      = din_d;
    assign bus.rvalid       = tag_q[RD_LAT-1];
    assign bus.rdata        = bus.ram_dout;
    assign bus.lock_timeout = timeout;

    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.gnt));
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.rvalid));
    a_locked_owner_only: assert property (@(posedge clk) disable iff (!reset)
        (state_q == ST_LOCKED) |-> ((bus.gnt & ~owner_mask) == '0));
endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port 64K x 8 data RAM between three requesters: CPU (port 0), UART loader (port 1) and UART dumper (port 2).
- Replaces the static cpu_enable mux, so the UART paths and the CPU can interleave accesses without the top-level FSM switching ownership.
- Arbitration is round-robin, one access per cycle, with an optional per-requester bus lock for bursts.
- Read data is returned with a valid strobe tagged to the requester that issued the read.

Parameters:
- AW, 16, RAM address width.
- DW, 8, RAM data width.
- NREQ, 3, number of requesters; the port order sets the index.
- RD_LAT, 1, RAM read latency in cycles (1 = registered block-RAM output).
- LOCK_MAX, 256, maximum consecutive cycles a lock may be held before forced release.

Ports:
- clk  in  1  system clock (the divided clock the RAM runs on).
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester access request; held until granted.
- we  in  NREQ  per-requester write enable, qualified by req.
- addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data.
- lock  in  NREQ  requester i asks to keep ownership after its grant.
- gnt  out  NREQ  one-hot grant; combinational, means the access is accepted this cycle.
- rvalid  out  NREQ  one-hot; read data for requester i is on rdata.
- rdata  out  DW  RAM read data, broadcast to all requesters.
- ram_we  out  1  to RAM wea.
- ram_addr  out  AW  to RAM addra.
- ram_din  out  DW  to RAM dina.
- ram_dout  in  DW  from RAM douta.
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly released.

Behaviour:
- Reset (reset=0, async):
  - FSM goes to ARB; round-robin pointer = 0; owner cleared; lock counter = 0.
  - rvalid tag pipeline cleared; lock_timeout = 0.
  - gnt = 0 and ram_we = 0 while reset is low.
- FSM has two states: ARB and LOCKED.
- ARB:
  - Winner = first requester with req=1, searching from pointer upward with wrap (NREQ-1 wraps to 0).
  - gnt[winner] = 1; the RAM ports are driven from the winner: ram_we = we[winner], ram_addr and ram_din from the winner's slices.
  - With no req: gnt = 0, ram_we = 0, ram_addr holds its last value.
  - On any grant: pointer <= winner+1 (mod NREQ).
  - If lock[winner] = 1 at grant: owner <= winner, counter <= 1, go to LOCKED.
- LOCKED:
  - Only the owner may be granted; other requesters stall with gnt = 0, and their requests are not lost.
  - Owner with req=1 is granted every cycle.
  - Owner dropping req while lock=1 still holds the bus; ram_we = 0 in those cycles.
  - lock[owner] = 0: release; go to ARB the next cycle. The cycle lock drops is still owner-only.
  - counter == LOCK_MAX: forced release; lock_timeout pulses 1 cycle; pointer <= owner+1; go to ARB. The owner must deassert lock and re-request.
  - Counter increments every LOCKED cycle and saturates.
- Read return:
  - Each accepted read (gnt & ~we) pushes a one-hot tag into an RD_LAT-deep shift register.
  - rvalid = tag at the pipe output, exactly RD_LAT cycles after gnt; rdata = ram_dout.
  - Accepted writes push a zero tag, so rvalid never fires for a write.
  - Back-to-back reads from different requesters return in issue order, one per cycle.
- Writes take effect at the grant-cycle edge.
  - Read of the same address in the next cycle returns the new data; the RAM is configured read-first / write-first consistently.
- Simultaneous events:
  - A lock request from a non-winner is ignored.
  - req and lock both dropping in LOCKED: release.
- Reset mid-burst clears the tags; in-flight reads produce no rvalid.

Test Plan:
- Round-robin fairness: req=3'b111 held 6 cycles, all reads → gnt sequence 001,010,100,001,010,100; rvalid follows each gnt by 1 cycle.
- Write/readback: port 1 writes addr 0x00FF data 0xA5, then port 2 reads 0x00FF → rvalid=3'b100, rdata=0xA5 one cycle after the read grant.
- Lock burst: port 0 locks and does 4 writes while port 1 requests → gnt stays 001 for 4 cycles; port 1 is granted the cycle after lock drops.
- Lock timeout with LOCK_MAX=8: port 2 holds lock and req → lock_timeout pulses at cycle 8, then port 0 is granted (pointer=0).
- Idle / write filtering: req=0 → ram_we=0, gnt=0; a write grant produces no rvalid.
- Async reset: reset low mid-LOCKED with one read in flight → gnt, rvalid and lock_timeout go 0 immediately; after reset, req=3'b110 grants port 1 first.
